// File: rtl/coreriscv_axi4_rr_arbiter.sv
// N-input request arbiter (fixed priority or round robin) with burst lock and a
// 2-entry registered output buffer, so no in_ready depends on out_ready.
module coreriscv_axi4_rr_arbiter #(
    parameter int N_IN   = 3,
    parameter int DATA_W = 8,
    parameter bit RR_MODE = 1'b1,
    localparam int CHW   = (N_IN > 2) ? $clog2(N_IN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN-1:0]        in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CHW-1:0]         out_chosen,
    output logic                   out_last
);
    localparam int BW = CHW + 1 + DATA_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } lock_state_t;

    lock_state_t     state_reg;
    logic [CHW-1:0]  lk_reg;
    logic [CHW-1:0]  ptr_reg;
    logic [1:0]      cnt_reg;
    logic [BW-1:0]   head_reg;
    logic [BW-1:0]   tail_reg;

    int              rr_off [N_IN];
    logic [CHW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [N_IN-1:0] gnt;
    logic            buf_full;
    logic            push;
    logic            pop;
    logic [DATA_W-1:0] acc_data;
    logic            acc_last;
    logic [BW-1:0]   acc_beat;

    // Distance of each requester from the round-robin pointer, modulo N_IN.
    // In fixed mode ptr_reg stays 0, so the smallest distance is the lowest index.
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_off
            assign rr_off[gi] = (gi >= int'(ptr_reg)) ? (gi - int'(ptr_reg))
                                                      : (gi + N_IN - int'(ptr_reg));
        end
    endgenerate

    always_comb begin
        int best;
        best    = N_IN;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (state_reg == BURST) begin
            gnt_idx = lk_reg;
            gnt_any = 1'b1;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_valid[i] && (rr_off[i] < best)) begin
                    best    = rr_off[i];
                    gnt_idx = CHW'(i);
                    gnt_any = 1'b1;
                end
            end
        end
    end

    assign buf_full = (cnt_reg == 2'd2);

    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_gnt
            assign gnt[gi]      = gnt_any & (gnt_idx == CHW'(gi));
            assign in_ready[gi] = gnt[gi] & ~buf_full & reset;
        end
    endgenerate

    always_comb begin
        acc_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (gnt[i]) begin
                acc_data = acc_data | in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign acc_last = |(in_last & gnt);
    assign acc_beat = {gnt_idx, acc_last, acc_data};
    assign push     = |(in_valid & in_ready);
    assign pop      = (cnt_reg != 2'd0) & out_ready;

    // Head/tail shift buffer: outputs always come straight from head_reg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= 2'd0;
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            case (cnt_reg)
                2'd0: begin
                    if (push) head_reg <= acc_beat;
                end
                2'd1: begin
                    if (push && pop) head_reg <= acc_beat;
                    else if (push)   tail_reg <= acc_beat;
                end
                default: begin
                    if (pop) head_reg <= tail_reg;
                end
            endcase
            cnt_reg <= cnt_reg + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            lk_reg    <= '0;
            ptr_reg   <= '0;
        end else if (push) begin
            if (acc_last) begin
                state_reg <= IDLE;
                if (RR_MODE) begin
                    ptr_reg <= (gnt_idx == CHW'(N_IN - 1)) ? '0 : CHW'(gnt_idx + 1'b1);
                end
            end else begin
                state_reg <= BURST;
                lk_reg    <= gnt_idx;
            end
        end
    end

    assign out_valid = (cnt_reg != 2'd0);
    assign {out_chosen, out_last, out_data} = head_reg;

endmodule

// File: tb/tb_coreriscv_axi4_rr_arbiter.sv
// Bench for the request arbiter: a round-robin and a fixed-priority instance share
// stimulus; each is compared every cycle against a queue-level reference model.
module tb_coreriscv_axi4_rr_arbiter;
    localparam int N  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_last;
    logic [N*DW-1:0] in_data;
    logic          out_ready;

    logic [N-1:0]  rr_in_ready, fx_in_ready;
    logic          rr_out_valid, fx_out_valid;
    logic [DW-1:0] rr_out_data, fx_out_data;
    logic [1:0]    rr_out_chosen, fx_out_chosen;
    logic          rr_out_last, fx_out_last;

    always #5 clk = ~clk;

    coreriscv_axi4_rr_arbiter #(.N_IN(N), .DATA_W(DW), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(rr_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(rr_out_valid), .out_ready(out_ready), .out_data(rr_out_data),
        .out_chosen(rr_out_chosen), .out_last(rr_out_last)
    );

    coreriscv_axi4_rr_arbiter #(.N_IN(N), .DATA_W(DW), .RR_MODE(1'b0)) u_fx (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(fx_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(fx_out_valid), .out_ready(out_ready), .out_data(fx_out_data),
        .out_chosen(fx_out_chosen), .out_last(fx_out_last)
    );

    typedef struct {
        bit lock;
        int lk;
        int ptr;
        int cnt;
        int d[2];
        int ch[2];
        int la[2];
    } mdl_t;

    mdl_t m_rr, m_fx;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0]   obs_rr_chosen, obs_fx_chosen;
    logic [N-1:0] obs_rr_ready;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.lock = 1'b0; s.lk = 0; s.ptr = 0; s.cnt = 0;
        for (int i = 0; i < 2; i++) begin
            s.d[i] = 0; s.ch[i] = 0; s.la[i] = 0;
        end
        return s;
    endfunction

    // Requester that would be offered ready this cycle, or -1 if none.
    function automatic int mdl_grant(input mdl_t s, input bit rr, input logic [N-1:0] v);
        if (s.lock) return s.lk;
        for (int i = 0; i < N; i++) begin
            int k;
            k = rr ? (s.ptr + i) % N : i;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input bit rr, input logic [N-1:0] v,
                                      input logic [N-1:0] l, input logic [N*DW-1:0] d,
                                      input logic ordy);
        mdl_t n;
        int   g;
        bit   push;
        bit   pop;
        n    = s;
        g    = mdl_grant(s, rr, v);
        push = (g >= 0) && v[g] && (s.cnt < 2);
        pop  = (s.cnt > 0) && ordy;
        if (pop) begin
            n.d[0] = s.d[1]; n.ch[0] = s.ch[1]; n.la[0] = s.la[1];
            n.cnt  = n.cnt - 1;
        end
        if (push) begin
            n.d[n.cnt]  = int'(d[g*DW +: DW]);
            n.ch[n.cnt] = g;
            n.la[n.cnt] = int'(l[g]);
            n.cnt       = n.cnt + 1;
            if (!l[g]) begin
                n.lock = 1'b1;
                n.lk   = g;
            end else begin
                n.lock = 1'b0;
                if (rr) n.ptr = (g + 1) % N;
            end
        end
        return n;
    endfunction

    task automatic compare(input string pfx, input mdl_t s, input bit rr, input logic [N-1:0] v,
                           input logic [N-1:0] rdy, input logic ov, input logic [DW-1:0] od,
                           input logic [1:0] oc, input logic ol);
        int g;
        int exp_rdy;
        g       = mdl_grant(s, rr, v);
        exp_rdy = (rst_n && (g >= 0) && (s.cnt < 2)) ? (1 << g) : 0;
        check_val({pfx, "_in_ready"}, int'(rdy), exp_rdy);
        check_val({pfx, "_out_valid"}, int'(ov), (s.cnt != 0) ? 1 : 0);
        if ((s.cnt != 0) || !rst_n) begin
            check_val({pfx, "_out_data"}, int'(od), s.d[0]);
            check_val({pfx, "_out_chosen"}, int'(oc), s.ch[0]);
            check_val({pfx, "_out_last"}, int'(ol), s.la[0]);
        end
    endtask

    task automatic cycle(input logic rst, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [N*DW-1:0] d, input logic ordy);
        @(negedge clk);
        rst_n     = rst;
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        if (!rst) begin
            m_rr = mdl_reset();
            m_fx = mdl_reset();
        end
        #1;
        compare("rr", m_rr, 1'b1, v, rr_in_ready, rr_out_valid, rr_out_data, rr_out_chosen, rr_out_last);
        compare("fx", m_fx, 1'b0, v, fx_in_ready, fx_out_valid, fx_out_data, fx_out_chosen, fx_out_last);
        obs_rr_chosen = rr_out_chosen;
        obs_fx_chosen = fx_out_chosen;
        obs_rr_ready  = rr_in_ready;
        if (rst) begin
            m_rr = mdl_step(m_rr, 1'b1, v, l, d, ordy);
            m_fx = mdl_step(m_fx, 1'b0, v, l, d, ordy);
        end
        @(posedge clk);
    endtask

    function automatic logic [N*DW-1:0] rnd_data();
        return (N*DW)'($urandom());
    endfunction

    initial begin
        rst_n     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        m_rr      = mdl_reset();
        m_fx      = mdl_reset();
        #1 rst_n  = 1'b0;

        // Reset held with every requester valid.
        for (int k = 0; k < 3; k++) cycle(1'b0, 3'b111, 3'b111, rnd_data(), 1'b1);

        // Round-robin fairness: 0,1,2,0,1,2 one beat per cycle.
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, 3'b111, 3'b111, rnd_data(), 1'b1);
            if (k >= 1) check_val("rr_seq_chosen", int'(obs_rr_chosen), (k - 1) % 3);
        end

        // Fixed priority: 1 beats 2, then 0 beats 1.
        for (int f = 0; f < 5; f++) begin
            cycle(1'b1, (f < 3) ? 3'b110 : 3'b111, 3'b111, rnd_data(), 1'b1);
            if (f == 2) check_val("fx_prio_1", int'(obs_fx_chosen), 1);
            if (f == 4) check_val("fx_prio_0", int'(obs_fx_chosen), 0);
        end

        // Burst from requester 2, with valid dropped for two cycles mid-burst.
        cycle(1'b1, 3'b100, 3'b000, rnd_data(), 1'b1);
        cycle(1'b1, 3'b111, 3'b011, rnd_data(), 1'b1);
        for (int b = 0; b < 2; b++) begin
            cycle(1'b1, 3'b011, 3'b111, rnd_data(), 1'b1);
            check_val("burst_hold_ready", int'(obs_rr_ready), 3'b100);
        end
        cycle(1'b1, 3'b111, 3'b111, rnd_data(), 1'b1);
        cycle(1'b1, 3'b111, 3'b111, rnd_data(), 1'b1);
        check_val("burst_after_ptr0", int'(obs_rr_ready), 3'b001);

        // Backpressure: only two beats absorbed, then drain.
        for (int p = 0; p < 4; p++) begin
            cycle(1'b1, 3'b111, 3'b111, rnd_data(), 1'b0);
            if (p >= 2) check_val("bp_ready_low", int'(obs_rr_ready), 0);
        end
        for (int p = 0; p < 4; p++) cycle(1'b1, 3'b111, 3'b111, rnd_data(), 1'b1);

        // Reset during a burst with the buffer full.
        for (int r = 0; r < 3; r++) cycle(1'b1, 3'b001, 3'b000, rnd_data(), 1'b0);
        for (int r = 0; r < 2; r++) cycle(1'b0, 3'b001, 3'b000, rnd_data(), 1'b0);
        cycle(1'b1, 3'b010, 3'b010, rnd_data(), 1'b1);
        cycle(1'b1, 3'b000, 3'b000, rnd_data(), 1'b1);
        check_val("post_rst_chosen", int'(obs_rr_chosen), 1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 99) != 0),
                  3'($urandom()),
                  3'($urandom()) | 3'($urandom()),
                  rnd_data(),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coreriscv_axi4_rr_arbiter.md
# coreriscv_axi4_rr_arbiter

Parametrised N-input arbiter for cache-metadata and refill request channels. Inputs can be arbitrated by fixed priority or by round robin. A grant can be held across a multi-beat burst. The winning beat is registered in a 2-entry output buffer, so no input `ready` depends combinationally on `out_ready`. It replaces the fixed 3-input combinational priority arbiter wherever the core needs more requesters, fairness, or a registered timing boundary.

## Interface
- `N_IN`, 3: number of requesters, 2..16.
- `DATA_W`, 8: payload width per requester (default covers a 7-bit idx plus 1-bit way_en).
- `RR_MODE`, 1: 1 = round robin; 0 = fixed priority, with the lowest index winning.
- `CHW`, derived as max(1, ceil(log2(N_IN))): width of the chosen index. Not overridable.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0); deassertion must be synchronous to `clk` upstream.
- `in_valid`  in  N_IN  per-requester valid.
- `in_ready`  out  N_IN  per-requester ready.
- `in_data`  in  N_IN*DATA_W  payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- `in_last`  in  N_IN  final beat of a burst; single-beat requests drive 1.
- `out_valid`  out  1  head of the output buffer is valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_data`  out  DATA_W  head payload.
- `out_chosen`  out  CHW  requester index of the head beat.
- `out_last`  out  1  `in_last` value of the head beat.

## Operation
- **Output buffer.** 2-entry FIFO with count `cnt` in 0..2.
  - Push when any `in_valid[k] & in_ready[k]`. Pop when `out_valid & out_ready`.
  - `out_valid = (cnt != 0)`. The head holds data, chosen index and last.
- **Grant.** One-hot `gnt` is computed combinationally each cycle.
  - If `lock` is set, `gnt` = the locked index `lk`, whether or not that input is valid.
  - Otherwise, in fixed mode, `gnt` = lowest valid index.
  - Otherwise, in round-robin mode, `gnt` = the first valid index found scanning from `ptr` upward, wrapping modulo N_IN.
  - If no input is valid, `gnt` = 0.
- **Ready.** `in_ready[k] = gnt[k] & (cnt != 2)`. At most one input is ready per cycle.
- **Accept of beat from requester k:**
  - If `in_last[k] = 0`: set `lock` and `lk = k`.
  - If `in_last[k] = 1`: clear `lock`. In round-robin mode, set `ptr = (k+1) mod N_IN`, wrapping N_IN-1 to 0.
  - `ptr` never moves on a non-last beat. In fixed mode `ptr` stays 0.
- **Lock state machine.** States IDLE (`lock = 0`) and BURST (`lock = 1`).
  - IDLE → BURST on accepting a beat with last = 0.
  - BURST → IDLE on accepting a beat from `lk` with last = 1.
  - In BURST, all other requesters see `in_ready = 0`, even if the locked requester drops valid mid-burst.
- **Simultaneous events.**
  - Push and pop in the same cycle: `cnt` is unchanged and data order is preserved.
  - When `cnt = 2`, push is blocked even if a pop occurs that cycle.
- **Reset (async, `reset = 0`):** `cnt = 0`, `out_valid = 0`, `out_data = 0`, `out_chosen = 0`, `out_last = 0`, `lock = 0`, `lk = 0`, `ptr = 0`, and `in_ready` is all-zero while reset is held. Reset during a burst discards buffered beats and clears the lock; there is no recovery of partial bursts.

## Timing
- Latency: a beat accepted at edge t appears on `out_*` after edge t, so it is available in cycle t+1 when the buffer was empty.
- Throughput: 1 beat/cycle sustained while `out_ready = 1`. In steady state `cnt` stays at 1.
- `in_ready` is a function of registered state (`cnt`, `lock`, `lk`, `ptr`) and `in_valid` only. There is no combinational path from `out_ready`.
- `out_*` are driven directly from buffer registers.
- With `out_ready = 0`, at most two beats are absorbed, after which `in_ready = 0`. The head must not change while `out_valid & !out_ready`.
- Arbitration decision, pointer update and lock update all take effect at the accepting edge.

## Test plan
- **Reset values:** hold reset low, drive all inputs valid → `in_ready = 0`, `out_valid = 0`, `out_chosen = 0`. After release, first grant goes to 0.
- **Round-robin fairness:** N_IN = 3, RR_MODE = 1, all valid, single-beat, `out_ready = 1` → `out_chosen` sequence 0,1,2,0,1,2, one beat per cycle from cycle 1 after release.
- **Fixed priority:** RR_MODE = 0, inputs 1 and 2 valid continuously → only 1 is granted. Raise input 0 → 0 is granted next cycle; 2 is never served while 1 stays valid.
- **Burst lock:** input 2 sends a 3-beat burst (last = 0,0,1) while 0 and 1 are valid → `out_chosen` = 2,2,2 consecutively. Input 2 drops valid for 2 cycles mid-burst → no other grant occurs. After the last beat, `ptr = 0` and input 0 wins.
- **Backpressure:** `out_ready = 0` with 4 beats offered → exactly 2 accepted, `in_ready = 0`, head stable. Raise `out_ready` → beats drain in order and `in_ready` reasserts the cycle after `cnt` drops below 2.
- **Reset mid-burst:** assert reset after the 1st beat of a burst with the buffer holding 2 entries → outputs return immediately to reset values. After release, a different requester can be granted.
